reg_bank_arbiter: RTL

//   Arbitrates two requesters (port 0, port 1) for read/write access to a bank
//   of NUM_REGS 8-bit registers built from d_flip_flop_8bit instances.

---
 rtl/reg_bank_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/reg_bank_arbiter.sv
// ============================================================================
// Module   : reg_bank_arbiter
// Purpose  : Round-robin arbiter giving two requesters read/write access to an
//            external bank of NUM_REGS 8-bit registers, one access at a time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank_arbiter #(
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_i,
   input  logic                  req1_i,
   input  logic                  we0_i,
   input  logic                  we1_i,
   input  logic [ADDR_W-1:0]     addr0_i,
   input  logic [ADDR_W-1:0]     addr1_i,
   input  logic [7:0]            wdata0_i,
   input  logic [7:0]            wdata1_i,
   output logic                  ack0_o,
   output logic                  ack1_o,
   output logic                  err_o,
   output logic [7:0]            rdata_o,
   output logic [NUM_REGS-1:0]   reg_en_o,
   output logic [7:0]            reg_d_o,
   input  logic [8*NUM_REGS-1:0] reg_q_i
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [ADDR_W:0] C_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

   logic [1:0]        state_q, state_d;
   logic              last_gnt_q;
   logic              gnt_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        wdata_q;
   logic [7:0]        rdata_q;

   logic              w_any_req;
   logic              w_win;
   logic              w_in_range;
   logic [7:0]        w_rsel;

   assign w_any_req  = req0_i | req1_i;
   // On contention the port that did not win last time gets the grant.
   assign w_win      = (req0_i & req1_i) ? ~last_gnt_q : req1_i;
   assign w_in_range = ({1'b0, addr_q} < C_NUM_REGS);

   always_comb begin
      w_rsel = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr_q == ADDR_W'(i)) begin
            w_rsel = reg_q_i[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (w_any_req) state_d = S_ACCESS;
         S_ACCESS: state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      reg_en_o = '0;
      ack0_o   = 1'b0;
      ack1_o   = 1'b0;
      err_o    = 1'b0;
      if (state_q == S_ACCESS && we_q && w_in_range) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            reg_en_o[i] = (addr_q == ADDR_W'(i));
         end
      end
      if (state_q == S_DONE) begin
         ack0_o = ~gnt_q;
         ack1_o = gnt_q;
         err_o  = ~w_in_range;
      end
   end

   assign reg_d_o = wdata_q;
   assign rdata_o = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q <= 1'b1;
         gnt_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 8'h00;
         rdata_q    <= 8'h00;
      end else begin
         if (state_q == S_IDLE && w_any_req) begin
            last_gnt_q <= w_win;
            gnt_q      <= w_win;
            we_q       <= w_win ? we1_i    : we0_i;
            addr_q     <= w_win ? addr1_i  : addr0_i;
            wdata_q    <= w_win ? wdata1_i : wdata0_i;
         end
         if (state_q == S_ACCESS) begin
            if (!w_in_range) begin
               rdata_q <= 8'h00;
            end else if (!we_q) begin
               rdata_q <= w_rsel;
            end
         end
      end
   end

endmodule

`default_nettype wire
